// File: rtl/updi_pkg.sv
// Shared constants, FSM states and the frame-build helper for the UPDI store character generator.
package updi_pkg;

  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned FRAME_W = 12;

  localparam logic [BYTE_W-1:0] SYNCH_CHAR    = 8'h55;
  localparam logic [BYTE_W-1:0] REPEAT_OP     = 8'hA0;
  localparam logic [BYTE_W-1:0] ST_PTR_INC_OP = 8'h66;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_GET_RPT,
    ST_SYNC1,
    ST_RPT_OP,
    ST_RPT_NUM,
    ST_SYNC2,
    ST_INSTR,
    ST_DATA,
    ST_DONE
  } state_e;

  // Frame layout: {2 stop bits, even parity, byte LSB-first, start bit}
  function automatic logic [FRAME_W-1:0] make_frame(input logic [BYTE_W-1:0] char_byte);
    return {2'b11, ^char_byte, char_byte, 1'b0};
  endfunction

endpackage

// File: rtl/updi_char_gen_if.sv
// APP-side byte handshake and PHY-side frame strobe of the UPDI character generator.
interface updi_char_gen_if;
  import updi_pkg::*;

  logic                 i_write;
  logic [BYTE_W-1:0]    i_data;
  logic                 i_valid;
  logic                 o_ready;
  logic                 o_write;
  logic [FRAME_W-1:0]   o_data;
  logic                 o_valid;
  logic                 o_trans_en;

  modport slave (
    input  i_write, i_data, i_valid,
    output o_ready, o_write, o_data, o_valid, o_trans_en
  );

  modport master (
    output i_write, i_data, i_valid,
    input  o_ready, o_write, o_data, o_valid, o_trans_en
  );

endinterface

// File: rtl/updi_frame_builder.sv
// Combinational byte -> 12-bit UART-style UPDI frame.
module updi_frame_builder
  import updi_pkg::*;
(
  input  logic [BYTE_W-1:0]  char_byte,
  output logic [FRAME_W-1:0] frame_c
);

  assign frame_c = make_frame(char_byte);

endmodule

// File: rtl/updi_char_gen.sv
// UPDI ST transaction character generator: fetches repeat count and payload from APP,
// emits SYNCH/REPEAT/ST/data frames to the PHY and pulses o_trans_en when complete.
module updi_char_gen
  import updi_pkg::*;
#(
  parameter int unsigned BYTES_PER_REPEAT = 4,
  parameter int unsigned CNT_W            = 10
) (
  input  logic           i_clk,
  input  logic           i_rstn,
  updi_char_gen_if.slave bus
);

  state_e               state_q, state_d;
  logic [BYTE_W-1:0]    rpt_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [CNT_W-1:0]     n_bytes_c;
  logic                 hs_c;
  logic                 last_c;
  logic [BYTE_W-1:0]    char_c;
  logic [FRAME_W-1:0]   frame_c;

  logic                 ready_q, ready_d;
  logic                 valid_q, valid_d;
  logic                 trans_q, trans_d;
  logic [FRAME_W-1:0]   data_q,  data_d;

  assign hs_c      = bus.i_valid & ready_q;
  assign last_c    = (cnt_q == CNT_W'(1));
  assign n_bytes_c = (bus.i_data == '0) ? CNT_W'(BYTES_PER_REPEAT)
                                        : CNT_W'(BYTES_PER_REPEAT) * CNT_W'(bus.i_data);

  updi_frame_builder u_frame (
    .char_byte (char_c),
    .frame_c   (frame_c)
  );

  // State, latched repeat count, byte counter and registered outputs
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= ST_IDLE;
      rpt_q   <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      trans_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      trans_q <= trans_d;
      data_q  <= data_d;
      if (state_q == ST_GET_RPT && hs_c) begin
        rpt_q <= bus.i_data;
        cnt_q <= n_bytes_c;
      end else if (state_q == ST_DATA && hs_c) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (bus.i_write) state_d = ST_GET_RPT;
      ST_GET_RPT: if (hs_c) state_d = ST_SYNC1;
      ST_SYNC1:   state_d = (rpt_q != '0) ? ST_RPT_OP : ST_INSTR;
      ST_RPT_OP:  state_d = ST_RPT_NUM;
      ST_RPT_NUM: state_d = ST_SYNC2;
      ST_SYNC2:   state_d = ST_INSTR;
      ST_INSTR:   state_d = ST_DATA;
      ST_DATA:    if (hs_c && last_c) state_d = ST_DONE;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Output logic: frame select and next values of the registered outputs
  always_comb begin
    char_c  = SYNCH_CHAR;
    valid_d = 1'b0;
    trans_d = 1'b0;
    unique case (state_q)
      ST_SYNC1, ST_SYNC2: valid_d = 1'b1;
      ST_RPT_OP:  begin char_c = REPEAT_OP;     valid_d = 1'b1; end
      ST_RPT_NUM: begin char_c = rpt_q;         valid_d = 1'b1; end
      ST_INSTR:   begin char_c = ST_PTR_INC_OP; valid_d = 1'b1; end
      ST_DATA:    begin char_c = bus.i_data;    valid_d = hs_c; end
      ST_DONE:    trans_d = 1'b1;
      default:    ;
    endcase
    ready_d = (state_d == ST_GET_RPT) || (state_d == ST_DATA);
    data_d  = valid_d ? frame_c : data_q;
  end

  assign bus.o_ready    = ready_q;
  assign bus.o_write    = ready_q;
  assign bus.o_valid    = valid_q;
  assign bus.o_trans_en = trans_q;
  assign bus.o_data     = data_q;

endmodule

// File: tb/tb_updi_char_gen.sv
// Randomized self-checking bench for updi_char_gen against a frame-list reference model.
module tb_updi_char_gen;
  import updi_pkg::*;

  logic i_clk  = 1'b0;
  logic i_rstn = 1'b0;
  always #5 i_clk = ~i_clk;

  updi_char_gen_if bus();

  updi_char_gen #(.BYTES_PER_REPEAT(4), .CNT_W(10)) dut (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [11:0] obs[$];
  logic [11:0] exp_q[$];
  logic [7:0]  fixed_bytes[$];
  int te_cnt = 0;
  int cyc = 0;
  int last_v_cyc = 0;
  int te_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, act, exp);
    end
  endtask

  // Reference frame: stop bits, even parity, byte shifted past the start bit
  function automatic logic [11:0] ref_frame(input logic [7:0] b);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    return 12'hC00 + 12'((ones % 2) * 512) + 12'(b) * 12'd2;
  endfunction

  // Frame / pulse monitor on the inactive edge
  initial begin
    forever begin
      @(negedge i_clk);
      cyc++;
      if (bus.o_valid) begin
        obs.push_back(bus.o_data);
        last_v_cyc = cyc;
      end
      if (bus.o_trans_en) begin
        te_cnt++;
        te_cyc = cyc;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    bit ok = 0;
    bus.i_valid = 1'b1;
    bus.i_data  = b;
    for (int k = 0; k < 50; k++) begin
      if (bus.o_ready) begin
        ok = 1;
        break;
      end
      @(negedge i_clk); #1;
    end
    if (!ok) chk("hs_timeout", 32'(ok), 32'd1);
    @(negedge i_clk); #1;
    bus.i_valid = 1'b0;
  endtask

  task automatic run_txn(input int r, input int stall_at, input int wr_at,
                         input int abort_at, input bit use_fixed);
    int n;
    int te0;
    int sz;
    logic [7:0] b;
    n = (r == 0) ? 4 : 4 * r;
    exp_q.delete();
    exp_q.push_back(12'hCAA);
    if (r != 0) begin
      exp_q.push_back(12'hD40);
      exp_q.push_back(ref_frame(8'(r)));
      exp_q.push_back(12'hCAA);
    end
    exp_q.push_back(12'hCCC);
    obs.delete();
    te0 = te_cnt;
    bus.i_write = 1'b1;
    @(negedge i_clk); #1;
    bus.i_write = 1'b0;
    send_byte(8'(r));
    for (int i = 0; i < n; i++) begin
      if (i == abort_at) begin
        #2 i_rstn = 1'b0;
        #1;
        chk("rst_valid", 32'(bus.o_valid), 0);
        chk("rst_data", 32'(bus.o_data), 0);
        chk("rst_ready", 32'(bus.o_ready), 0);
        chk("rst_write", 32'(bus.o_write), 0);
        chk("rst_trans", 32'(bus.o_trans_en), 0);
        repeat (3) begin @(negedge i_clk); #1; end
        chk("rst_no_trans", 32'(te_cnt - te0), 0);
        i_rstn = 1'b1;
        @(negedge i_clk); #1;
        return;
      end
      b = use_fixed ? fixed_bytes[i] : 8'($urandom);
      exp_q.push_back(ref_frame(b));
      if (i == wr_at) bus.i_write = 1'b1;
      send_byte(b);
      bus.i_write = 1'b0;
      if (i == stall_at) begin
        sz = obs.size();
        repeat (3) begin @(negedge i_clk); #1; end
        chk("stall_gap", 32'(obs.size()), 32'(sz));
      end
    end
    for (int k = 0; k < 10; k++) begin
      if (te_cnt != te0) break;
      @(negedge i_clk); #1;
    end
    repeat (3) begin @(negedge i_clk); #1; end
    chk("trans_pulses", 32'(te_cnt - te0), 1);
    chk("trans_latency", 32'(te_cyc - last_v_cyc), 1);
    chk("ready_idle", 32'(bus.o_ready), 0);
    chk("frame_count", 32'(obs.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++)
      chk($sformatf("frame[%0d]", i), 32'(obs[i]), 32'(exp_q[i]));
  endtask

  initial begin
    bus.i_write = 1'b0;
    bus.i_data  = '0;
    bus.i_valid = 1'b0;
    #1;
    chk("reset_valid", 32'(bus.o_valid), 0);
    chk("reset_data", 32'(bus.o_data), 0);
    chk("reset_ready", 32'(bus.o_ready), 0);
    chk("reset_trans", 32'(bus.o_trans_en), 0);
    repeat (2) @(negedge i_clk);
    #1 i_rstn = 1'b1;
    @(negedge i_clk); #1;

    run_txn(10, -1, -1, -1, 1'b0);

    fixed_bytes = '{8'h01, 8'hFF, 8'h00, 8'h80};
    run_txn(0, -1, -1, -1, 1'b1);
    chk("parity_01", 32'(obs[2]), 32'h0E02);
    chk("parity_ff", 32'(obs[3]), 32'h0DFE);
    chk("parity_00", 32'(obs[4]), 32'h0C00);

    run_txn(6, 3, -1, -1, 1'b0);
    run_txn(5, -1, 7, -1, 1'b0);
    run_txn(3, -1, -1, 5, 1'b0);
    chk("post_reset_ready", 32'(bus.o_ready), 0);
    run_txn(2, -1, -1, -1, 1'b0);
    run_txn(int'($urandom_range(1, 8)), int'($urandom_range(0, 3)), -1, -1, 1'b0);
    run_txn(255, 100, 500, -1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/updi_char_gen.md
Name: updi_char_gen

Overview:
- UPDI character generator for a store (ST) transaction.
- Sits between the application data source (APP) and the PHY frame memory/transmitter.
- On a write command it requests the repeat count and the payload bytes from APP, then emits 12-bit UART-style UPDI frames to the PHY: SYNCH, optional REPEAT, instruction, data.
- Pulses o_trans_en when the whole transaction has been written.

Parameters:
BYTES_PER_REPEAT, 4, data bytes transferred per repeat unit.
CNT_W, 10, width of the data-byte counter; must hold 255*BYTES_PER_REPEAT.

Ports:
i_clk  in  1  clock, rising edge.
i_rstn  in  1  asynchronous active-low reset.
i_write  in  1  write-command pulse from the external command block; starts a transaction.
i_data  in  8  byte from APP: first the repeat count R, then payload bytes.
i_valid  in  1  i_data valid.
o_ready  out  1  byte accepted when i_valid && o_ready at a rising edge.
o_write  out  1  request to APP to supply the repeat count and payload.
o_data  out  12  frame to PHY.
o_valid  out  1  one-cycle strobe; o_data is valid.
o_trans_en  out  1  one-cycle pulse: transaction fully written, PHY may transmit.

Behaviour:
- One clock (i_clk); reset is asynchronous and active-low (i_rstn).
- Reset values: all outputs 0; state IDLE; counters 0.
- Frame format: o_data = {2'b11 stop, parity, byte[7:0], 1'b0 start}.
  - Parity is even: bit9 = ^byte.
  - Byte bit0 is at o_data[1].
- Constants:
  - SYNCH 0x55 -> frame 0xCAA.
  - REPEAT opcode 0xA0 -> frame 0xD40.
  - ST opcode 0x66 (ST *(ptr++)) -> frame 0xCCC.
- Byte count N = BYTES_PER_REPEAT*R if R != 0; N = BYTES_PER_REPEAT if R == 0.
- States and transitions:
  - IDLE: i_write=1 -> GET_RPT. Any other input is ignored.
  - GET_RPT: o_write=1, o_ready=1. On handshake latch R, load counter with N -> SYNC1.
  - SYNC1: emit SYNCH (o_valid=1 for one cycle). Go to RPT_OP if R != 0, else INSTR.
  - RPT_OP: emit 0xA0 -> RPT_NUM.
  - RPT_NUM: emit frame of R -> SYNC2.
  - SYNC2: emit SYNCH -> INSTR.
  - INSTR: emit 0x66 -> DATA.
  - DATA: o_write=1, o_ready=1.
    - Each handshake registers the frame of i_data with o_valid=1 at that same edge, so it is visible the following cycle; decrement counter.
    - On the last byte, deassert o_ready/o_write -> DONE.
  - DONE: o_trans_en=1 for one cycle -> IDLE.
- Each header state lasts exactly one cycle. Frames are registered outputs; o_valid is never high for two cycles with the same frame.
- The PHY side has no backpressure: the downstream memory accepts one frame per cycle.
- i_valid low in GET_RPT or DATA: stall, no frame emitted, o_ready stays high.
- i_write while not IDLE: ignored.
- R=255: N=1020, must not overflow CNT_W.
- Reset mid-transaction: immediate abort to IDLE, outputs cleared, no o_trans_en.
- o_data holds its last value when o_valid=0.

Decomposition:
- Package updi_pkg:
  - SYNCH_CHAR, REPEAT_OP, ST_PTR_INC_OP constants;
  - state enum;
  - function make_frame(byte) returning the 12-bit frame with parity.
- Optional sub-module updi_frame_builder: combinational byte -> 12-bit frame. The FSM stays in one module.

Test Plan:
- Nominal, R=10:
  - Stimulus: i_write pulse; APP sends 0x0A then 40 random bytes.
  - Required response: frames 0xCAA, 0xD40, 0xC14, 0xCAA, 0xCCC, then 40 data frames matching sent bytes in order with correct start/parity/stop.
  - o_trans_en pulses once, 1 cycle after the last data frame's acceptance edge.
- R=0:
  - Stimulus: i_write pulse; APP sends 0x00 then 4 bytes.
  - Required response: frames 0xCAA, 0xCCC, then 4 data frames; no 0xD40; o_trans_en pulse.
- Parity:
  - Data 0x01 -> 0xE02; data 0xFF -> 0xDFE; data 0x00 -> 0xC00.
- APP stalls:
  - Stimulus: drop i_valid for 3 cycles between data bytes.
  - Required response: no o_valid during the gap; byte order preserved; total frame count unchanged.
- Extra i_write:
  - Stimulus: i_write asserted during the DATA state.
  - Required response: ignored; frame sequence identical to nominal.
- Reset mid-DATA:
  - Stimulus: assert i_rstn low after 5 data bytes.
  - Required response: all outputs 0 asynchronously; no o_trans_en.
  - After release, a new i_write runs a complete correct transaction.
